// File: rtl/osc_freq_meter.sv
// Ring-oscillator frequency meter: counts synchronized rising edges of osc_in over a
// programmable window of clk cycles. Optional macro OSC_GLITCH_FILTER_EN adds a 2-sample glitch filter.
module osc_freq_meter #(
    parameter int GATE_W      = 16,
    parameter int CNT_W       = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              osc_in,
    input  logic              start,
    input  logic [GATE_W-1:0] gate_cycles,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  count,
    output logic              overflow
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_GATE = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0]  CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [GATE_W-1:0] GATE_ONE = {{(GATE_W-1){1'b0}}, 1'b1};

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   osc_s;
    logic                   level;
    logic                   prev_q;
    logic                   osc_edge;

    state_t                 state_q, state_d;
    logic [GATE_W-1:0]      timer_q, timer_d;
    logic [CNT_W-1:0]       count_q, count_d;
    logic                   ovf_q, ovf_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], osc_in};
        end
    end

    assign osc_s = sync_q[SYNC_STAGES-1];

`ifdef OSC_GLITCH_FILTER_EN
    logic hist_q;
    logic filt_q;

    // The filtered level only follows osc_s once two consecutive samples agree.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hist_q <= 1'b0;
            filt_q <= 1'b0;
        end else begin
            hist_q <= osc_s;
            if (osc_s == hist_q) begin
                filt_q <= osc_s;
            end
        end
    end

    assign level = filt_q;
`else
    assign level = osc_s;
`endif

    // History runs in every state so a level already high at start is not an edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev_q <= 1'b0;
        end else begin
            prev_q <= level;
        end
    end

    assign osc_edge = level & ~prev_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            timer_q <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        count_d = count_q;
        ovf_d   = ovf_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                busy_d = 1'b0;
                if (start) begin
                    count_d = '0;
                    ovf_d   = 1'b0;
                    busy_d  = 1'b1;
                    if (gate_cycles == '0) begin
                        // Zero-length window: busy covers just the DONE cycle.
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = ST_GATE;
                        timer_d = gate_cycles;
                    end
                end
            end
            ST_GATE: begin
                if (osc_edge) begin
                    if (count_q == CNT_MAX) begin
                        ovf_d = 1'b1;
                    end else begin
                        count_d = count_q + 1'b1;
                    end
                end
                timer_d = timer_q - GATE_ONE;
                if (timer_q == GATE_ONE) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
                timer_d = '0;
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign count    = count_q;
    assign overflow = ovf_q;

endmodule
